stream_prefetch_ctrl: RTL and testbench

- Parametrised successor to the single-line prefetch controller. Sits between the cache's memory port and main memory.
- Keeps a DEPTH-entry stream buffer of sequential lines and prefetches PF_DEGREE lines past each demand miss.
- Serves cache reads from the buffer on a hit. Forwards data from an in-flight prefetch when the demand address matches it.

---
 rtl/stream_prefetch_ctrl_if.sv | 22 ++
 rtl/stream_prefetch_ctrl.sv | 163 ++++++++++++++++
 tb/tb_stream_prefetch_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_prefetch_ctrl_if.sv
// stream_prefetch_ctrl_if: cache-side and memory-side handshake bundle of the stream prefetcher
interface stream_prefetch_ctrl_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
);
  logic              cache_mem_read;
  logic [ADDR_W-1:0] cache_mem_addr;
  logic [DATA_W-1:0] cache_mem_rdata;
  logic              cache_mem_ready;
  logic              mem_read;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  modport slave (
    input  cache_mem_read, cache_mem_addr, mem_rdata, mem_ready,
    output cache_mem_rdata, cache_mem_ready, mem_read, mem_addr
  );
  modport master (
    output cache_mem_read, cache_mem_addr, mem_rdata, mem_ready,
    input  cache_mem_rdata, cache_mem_ready, mem_read, mem_addr
  );
endinterface

// File: rtl/stream_prefetch_ctrl.sv
// stream_prefetch_ctrl: DEPTH-entry sequential stream buffer with demand pass-through and in-flight forwarding
module stream_prefetch_ctrl #(
  parameter int ADDR_W    = 28,
  parameter int DATA_W    = 128,
  parameter int DEPTH     = 4,
  parameter int PF_DEGREE = 2,
  parameter int CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pf_en,
  stream_prefetch_ctrl_if.slave bus,
  output logic [CNT_W-1:0]      hit_cnt,
  output logic [CNT_W-1:0]      miss_cnt
);
  localparam int PW   = $clog2(DEPTH);
  localparam int PL_W = $clog2(DEPTH + 1);
  typedef enum logic [1:0] {IDLE, DEMAND, PREFETCH} state_t;
  state_t            state_q, state_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PL_W-1:0]   pf_left_q, pf_left_d;
  logic [ADDR_W-1:0] next_pf_q, next_pf_d, mem_addr_q, mem_addr_d;
  logic              mem_read_q, mem_read_d, ready_q, ready_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  hit_q, hit_d, miss_q, miss_d;
  logic              req_hit, pf_dup, accept, fwd;
  logic [PW-1:0]     hit_idx;
  logic [PL_W-1:0]   n_valid, room, pf_cap;
  always_comb begin
    req_hit = 1'b0;
    pf_dup  = 1'b0;
    hit_idx = '0;
    n_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      n_valid = n_valid + PL_W'(valid_q[i]);
      if (valid_q[i] && addr_q[i] == bus.cache_mem_addr) begin
        req_hit = 1'b1;
        hit_idx = PW'(i);
      end
      if (valid_q[i] && addr_q[i] == next_pf_q) pf_dup = 1'b1;
    end
  end
  // room counts free slots once the hit entry has been consumed
  assign room   = PL_W'(DEPTH + 1) - n_valid;
  assign pf_cap = (PL_W'(PF_DEGREE) < room) ? PL_W'(PF_DEGREE) : room;
  assign accept = bus.cache_mem_read && !ready_q;
  assign fwd    = bus.cache_mem_read && bus.cache_mem_addr == mem_addr_q;
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    addr_d     = addr_q;
    data_d     = data_q;
    ptr_d      = ptr_q;
    pf_left_d  = pf_left_q;
    next_pf_d  = next_pf_q;
    mem_read_d = mem_read_q;
    mem_addr_d = mem_addr_q;
    ready_d    = 1'b0;
    rdata_d    = rdata_q;
    hit_d      = hit_q;
    miss_d     = miss_q;
    case (state_q)
      IDLE: begin
        if (accept && pf_en && req_hit) begin
          ready_d          = 1'b1;
          rdata_d          = data_q[hit_idx];
          valid_d[hit_idx] = 1'b0;
          hit_d            = hit_q + CNT_W'(!(&hit_q));
          next_pf_d        = (pf_left_q == '0) ? bus.cache_mem_addr + 1'b1 : next_pf_q;
          pf_left_d        = (pf_left_q == '0) ? pf_cap : pf_left_q;
        end else if (accept) begin
          valid_d    = '0;
          mem_read_d = 1'b1;
          mem_addr_d = bus.cache_mem_addr;
          state_d    = DEMAND;
          next_pf_d  = bus.cache_mem_addr + 1'b1;
          pf_left_d  = PL_W'(PF_DEGREE);
          miss_d     = miss_q + CNT_W'(!(&miss_q));
        end else if (pf_en && pf_left_q != '0) begin
          // a line already buffered counts as prefetched without touching memory
          if (pf_dup) begin
            next_pf_d = next_pf_q + 1'b1;
            pf_left_d = pf_left_q - 1'b1;
          end else if (!(&valid_q)) begin
            mem_read_d = 1'b1;
            mem_addr_d = next_pf_q;
            state_d    = PREFETCH;
          end
        end
      end
      DEMAND: begin
        if (bus.mem_ready) begin
          ready_d    = 1'b1;
          rdata_d    = bus.mem_rdata;
          mem_read_d = 1'b0;
          state_d    = IDLE;
        end
      end
      PREFETCH: begin
        if (bus.mem_ready) begin
          if (fwd) begin
            ready_d = 1'b1;
            rdata_d = bus.mem_rdata;
            hit_d   = hit_q + CNT_W'(!(&hit_q));
          end else begin
            valid_d[ptr_q] = 1'b1;
            addr_d[ptr_q]  = mem_addr_q;
            data_d[ptr_q]  = bus.mem_rdata;
            ptr_d          = ptr_q + 1'b1;
          end
          next_pf_d  = next_pf_q + 1'b1;
          pf_left_d  = pf_left_q - PL_W'(pf_left_q != '0);
          mem_read_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!pf_en) pf_left_d = '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      ptr_q      <= '0;
      pf_left_q  <= '0;
      next_pf_q  <= '0;
      mem_read_q <= 1'b0;
      mem_addr_q <= '0;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      hit_q      <= '0;
      miss_q     <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      ptr_q      <= ptr_d;
      pf_left_q  <= pf_left_d;
      next_pf_q  <= next_pf_d;
      mem_read_q <= mem_read_d;
      mem_addr_q <= mem_addr_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
    end
  end
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end
  assign bus.mem_read        = mem_read_q;
  assign bus.mem_addr        = mem_addr_q;
  assign bus.cache_mem_ready = ready_q;
  assign bus.cache_mem_rdata = rdata_q;
  assign hit_cnt             = hit_q;
  assign miss_cnt            = miss_q;
endmodule

// File: tb/tb_stream_prefetch_ctrl.sv
// tb_stream_prefetch_ctrl: directed scenarios checked against a transaction-level buffer model and literal expectations
module tb_stream_prefetch_ctrl;
  localparam int AW = 28, DW = 128, DEPTH = 4, PF = 2, CW = 16;
  logic clk, rst, pf_en;
  logic [CW-1:0] hit_cnt, miss_cnt;
  int checks = 0, errors = 0, cyc = 0, mem_lat = 3, mem_done = 0, wcnt = 0;
  logic [AW-1:0] issued [$];
  stream_prefetch_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  stream_prefetch_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .PF_DEGREE(PF), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .pf_en(pf_en), .bus(bus), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );
  function automatic logic [DW-1:0] line(input logic [AW-1:0] a);
    line = {4'hA, a, 4'h5, ~a, 4'hC, a, 4'h3, ~a};
  endfunction
  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial forever @(posedge clk) cyc++;
  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  // memory: mem_ready in the mem_lat-th cycle of mem_read, single pulse
  initial begin
    bus.mem_ready = 0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        wcnt = 0;
        bus.mem_ready = 0;
      end else if (bus.mem_ready) bus.mem_ready = 0;
      else if (bus.mem_read) begin
        if (wcnt >= mem_lat - 1) begin
          bus.mem_ready = 1;
          bus.mem_rdata = line(bus.mem_addr);
          wcnt = 0;
          mem_done = cyc;
        end else wcnt++;
      end
    end
  end
  initial begin
    bit prev = 0;
    forever begin
      @(negedge clk);
      if (!rst && bus.mem_read && !prev) issued.push_back(bus.mem_addr);
      prev = !rst && bus.mem_read;
    end
  end
  // model: stream buffer as arrays, the controller as a busy mode (0 idle, 1 demand, 2 prefetch)
  bit            m_valid [DEPTH];
  logic [AW-1:0] m_addr [DEPTH];
  logic [DW-1:0] m_data [DEPTH];
  int            m_ptr, m_mode, m_left;
  logic [AW-1:0] m_next, m_mem_addr;
  logic          m_mem_read, m_ready;
  logic [DW-1:0] m_rdata;
  logic [CW-1:0] m_hit, m_miss;
  function automatic int find(input logic [AW-1:0] a);
    find = -1;
    for (int i = 0; i < DEPTH; i++) if (m_valid[i] && m_addr[i] == a) find = i;
  endfunction
  function automatic int used();
    used = 0;
    for (int i = 0; i < DEPTH; i++) used += int'(m_valid[i]);
  endfunction
  function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
    sat = (v == '1) ? v : v + 1'b1;
  endfunction
  initial begin
    int idx;
    bit was_ready;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
        m_ptr = 0; m_mode = 0; m_left = 0; m_next = 0; m_mem_addr = 0;
        m_mem_read = 0; m_ready = 0; m_rdata = 0; m_hit = 0; m_miss = 0;
      end else begin
        was_ready = m_ready;
        m_ready = 0;
        if (m_mode == 0) begin
          idx = find(bus.cache_mem_addr);
          if (bus.cache_mem_read && !was_ready) begin
            if (pf_en && idx >= 0) begin
              m_ready = 1;
              m_rdata = m_data[idx];
              m_valid[idx] = 0;
              m_hit = sat(m_hit);
              if (m_left == 0) begin
                m_next = bus.cache_mem_addr + 1;
                m_left = (PF < DEPTH - used()) ? PF : DEPTH - used();
              end
            end else begin
              for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
              m_mem_read = 1; m_mem_addr = bus.cache_mem_addr; m_mode = 1;
              m_next = bus.cache_mem_addr + 1; m_left = PF; m_miss = sat(m_miss);
            end
          end else if (pf_en && m_left > 0) begin
            if (find(m_next) >= 0) begin
              m_next = m_next + 1;
              m_left--;
            end else if (used() < DEPTH) begin
              m_mem_read = 1; m_mem_addr = m_next; m_mode = 2;
            end
          end
        end else if (bus.mem_ready) begin
          if (m_mode == 1) begin
            m_ready = 1; m_rdata = bus.mem_rdata;
          end else begin
            if (bus.cache_mem_read && bus.cache_mem_addr == m_mem_addr) begin
              m_ready = 1; m_rdata = bus.mem_rdata; m_hit = sat(m_hit);
            end else begin
              m_valid[m_ptr] = 1; m_addr[m_ptr] = m_mem_addr; m_data[m_ptr] = bus.mem_rdata;
              m_ptr = (m_ptr + 1) % DEPTH;
            end
            m_next = m_next + 1;
            if (m_left > 0) m_left--;
          end
          m_mem_read = 0; m_mode = 0;
        end
        if (!pf_en) m_left = 0;
      end
    end
  end
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("cache_mem_ready", bus.cache_mem_ready, m_ready);
      chk("cache_mem_rdata", bus.cache_mem_rdata, m_rdata);
      chk("mem_read", bus.mem_read, m_mem_read);
      chk("mem_addr", bus.mem_addr, m_mem_addr);
      chk("hit_cnt", hit_cnt, m_hit);
      chk("miss_cnt", miss_cnt, m_miss);
    end
  end
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_read(input logic [AW-1:0] a, output int n, output logic [DW-1:0] d, output int rc);
    bus.cache_mem_addr = a;
    bus.cache_mem_read = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.cache_mem_ready && n < 100);
    if (n >= 100) chk("read_timeout", 1'b1, 1'b0);
    d = bus.cache_mem_rdata;
    rc = cyc;
    bus.cache_mem_read = 0;
    @(negedge clk);
  endtask
  initial begin
    int n, rc, n0;
    logic [DW-1:0] d;
    bit found;
    rst = 1; pf_en = 1;
    bus.cache_mem_read = 0; bus.cache_mem_addr = '0;
    idle(2);
    chk("rst_mem_read", bus.mem_read, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_ready", bus.cache_mem_ready, 0);
    chk("rst_rdata", bus.cache_mem_rdata, 0);
    chk("rst_cnts", {hit_cnt, miss_cnt}, 0);
    rst = 0;
    idle(1);
    do_read(28'h10, n, d, rc);
    chk("t1_latency", n, 4);
    chk("t1_data", d, line(28'h10));
    chk("t1_ready_gap", rc - mem_done, 1);
    chk("t1_miss_cnt", miss_cnt, 1);
    idle(30);
    chk("t1_issued_n", issued.size(), 3);
    chk("t1_issued", {issued[0], issued[1], issued[2]}, {28'h10, 28'h11, 28'h12});
    do_read(28'h11, n, d, rc);
    chk("t2_latency", n, 1);
    chk("t2_data", d, line(28'h11));
    chk("t2_hit_cnt", hit_cnt, 1);
    idle(20);
    chk("t2_issued_n", issued.size(), 4);
    chk("t2_refill", issued[3], 28'h13);
    do_read(28'h11, n, d, rc);
    chk("t3_miss_cnt", miss_cnt, 2);
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (bus.mem_read && bus.mem_addr == 28'h12) found = 1;
      else @(negedge clk);
    end
    chk("t3_pf_seen", found, 1);
    do_read(28'h12, n, d, rc);
    chk("t3_fwd_data", d, line(28'h12));
    chk("t3_fwd_gap", rc - mem_done, 1);
    chk("t3_hit_cnt", hit_cnt, 2);
    idle(20);
    do_read(28'h12, n, d, rc);
    chk("t3_reread_lat", n, 4);
    chk("t3_reread_miss", miss_cnt, 3);
    idle(30);
    mem_lat = 1;
    n0 = issued.size();
    do_read(28'hFFFFFFF, n, d, rc);
    chk("t4_latency", n, 2);
    chk("t4_data", d, line(28'hFFFFFFF));
    idle(20);
    chk("t4_issued_n", issued.size(), n0 + 3);
    chk("t4_wrap", {issued[n0+1], issued[n0+2]}, {28'h0, 28'h1});
    do_read(28'h0, n, d, rc);
    chk("t4_wrap_hit_lat", n, 1);
    chk("t4_wrap_hit_data", d, line(28'h0));
    chk("t4_cnts", {hit_cnt, miss_cnt}, {16'd3, 16'd4});
    idle(10);
    rst = 1; pf_en = 0; mem_lat = 3;
    idle(1);
    rst = 0;
    issued.delete();
    do_read(28'h20, n, d, rc);
    chk("t5_lat_a", n, 4);
    do_read(28'h21, n, d, rc);
    chk("t5_lat_b", n, 4);
    chk("t5_data_b", d, line(28'h21));
    idle(20);
    chk("t5_cnts", {hit_cnt, miss_cnt}, {16'd0, 16'd2});
    chk("t5_issued_n", issued.size(), 2);
    chk("t5_issued", {issued[0], issued[1]}, {28'h20, 28'h21});
    pf_en = 1; mem_lat = 8;
    do_read(28'h50, n, d, rc);
    chk("t6_latency", n, 9);
    idle(40);
    bus.cache_mem_addr = 28'h70;
    bus.cache_mem_read = 1;
    idle(2);
    chk("t6_in_demand", {bus.mem_read, bus.mem_addr}, {1'b1, 28'h70});
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("t6_async_mem_read", bus.mem_read, 0);
    chk("t6_async_mem_addr", bus.mem_addr, 0);
    chk("t6_async_ready", bus.cache_mem_ready, 0);
    chk("t6_async_cnts", {hit_cnt, miss_cnt}, 0);
    bus.cache_mem_read = 0;
    @(posedge clk);
    #2 rst = 0;
    idle(1);
    do_read(28'h51, n, d, rc);
    chk("t6_after_rst_lat", n, 9);
    chk("t6_after_rst_data", d, line(28'h51));
    chk("t6_after_rst_cnts", {hit_cnt, miss_cnt}, {16'd0, 16'd1});
    idle(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
